// File: rtl/instruction_fetch_unit.sv
// Instruction fetch stage: holds the program memory, latches the word addressed by
// pc_in into the instruction register and hands opcode/operand to execute.
module instruction_fetch_unit #(
  parameter int ADDR_W = 3,
  parameter int INSTR_W = 8,
  parameter int OPC_W = 4,
  parameter logic [OPC_W-1:0] HALT_OPC = 4'hF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [ADDR_W-1:0]        pc_in,
  input  logic                     prog_we,
  input  logic [ADDR_W-1:0]        prog_addr,
  input  logic [INSTR_W-1:0]       prog_data,
  input  logic                     stall,
  output logic [INSTR_W-1:0]       ir_out,
  output logic [OPC_W-1:0]         opcode,
  output logic [INSTR_W-OPC_W-1:0] operand,
  output logic                     instr_valid,
  output logic                     halted,
  output logic [3:0]               instr_count
);

  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DECODE,
    HALTED
  } state_t;

  state_t state;

  logic [INSTR_W-1:0] mem [DEPTH];
  logic [INSTR_W-1:0] fetch_word;

  // Program memory has no reset so a loaded program survives rst; loads are
  // accepted in every state, and the fetch below sees the pre-write word.
  always_ff @(posedge clk) begin
    if (prog_we) begin
      mem[prog_addr] <= prog_data;
    end
  end

  assign fetch_word = mem[pc_in];

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      ir_out      <= '0;
      opcode      <= '0;
      operand     <= '0;
      instr_valid <= 1'b0;
      halted      <= 1'b0;
      instr_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          state <= FETCH;
        end
        FETCH: begin
          ir_out      <= fetch_word;
          opcode      <= fetch_word[INSTR_W-1 -: OPC_W];
          operand     <= fetch_word[INSTR_W-OPC_W-1:0];
          instr_valid <= 1'b1;
          state       <= DECODE;
        end
        DECODE: begin
          // A stalled execute stage keeps the decoded instruction on the outputs.
          if (!stall) begin
            instr_count <= instr_count + 4'd1;
            instr_valid <= 1'b0;
            if (opcode == HALT_OPC) begin
              halted <= 1'b1;
              state  <= HALTED;
            end else begin
              state <= FETCH;
            end
          end
        end
        HALTED: begin
          state <= HALTED;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Scoreboard bench for instruction_fetch_unit: the driver pushes the word each fetch
// should return, a negedge monitor pops on every new instruction and checks timing.
module tb_instruction_fetch_unit;

  logic       clk;
  logic       rst;
  logic [2:0] pc_in;
  logic       prog_we;
  logic [2:0] prog_addr;
  logic [7:0] prog_data;
  logic       stall;
  logic [7:0] ir_out;
  logic [3:0] opcode;
  logic [3:0] operand;
  logic       instr_valid;
  logic       halted;
  logic [3:0] instr_count;

  instruction_fetch_unit dut (
    .clk         (clk),
    .rst         (rst),
    .pc_in       (pc_in),
    .prog_we     (prog_we),
    .prog_addr   (prog_addr),
    .prog_data   (prog_data),
    .stall       (stall),
    .ir_out      (ir_out),
    .opcode      (opcode),
    .operand     (operand),
    .instr_valid (instr_valid),
    .halted      (halted),
    .instr_count (instr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [7:0] memModel [8];
  logic [7:0] sb [$];
  bit         monEnable = 0;
  bit         randWrites = 0;

  // Monitor-side reference state
  logic [7:0] cur = 8'h00;
  logic [7:0] haltWord = 8'h00;
  int         expCount = 0;
  bit         expHalted = 0;
  bit         prevValid = 0;
  bit         accPrev = 0;
  bit         accPrev2 = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (monEnable) begin
      if (accPrev) checkOutput("valid_drop_after_accept", instr_valid, 0);
      if (accPrev2 && !expHalted) checkOutput("refetch_latency", instr_valid, 1);
      if (instr_valid && !prevValid) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_instr: got ir %0h expected none", ir_out);
        end else begin
          cur = sb.pop_front();
        end
      end
      if (instr_valid) begin
        checkOutput("ir_out", ir_out, cur);
        checkOutput("opcode", opcode, cur / 16);
        checkOutput("operand", operand, cur % 16);
      end
      checkOutput("instr_count", instr_count, expCount);
      checkOutput("halted", halted, expHalted);
      if (expHalted) begin
        checkOutput("halt_valid", instr_valid, 0);
        checkOutput("halt_ir", ir_out, haltWord);
        checkOutput("halt_opcode", opcode, haltWord / 16);
        checkOutput("halt_operand", operand, haltWord % 16);
      end
      accPrev2 = accPrev;
      accPrev = instr_valid && !stall && !expHalted;
      if (accPrev) begin
        expCount = (expCount + 1) % 16;
        if (cur / 16 == 15) begin
          expHalted = 1;
          haltWord = cur;
        end
      end
      prevValid = instr_valid;
    end
  end

  task automatic doReset();
    monEnable = 0;
    stall = 1'b0;
    prog_we = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    checkOutput("rst_ir", ir_out, 0);
    checkOutput("rst_opcode", opcode, 0);
    checkOutput("rst_operand", operand, 0);
    checkOutput("rst_valid", instr_valid, 0);
    checkOutput("rst_halted", halted, 0);
    checkOutput("rst_count", instr_count, 0);
    sb.delete();
    expCount = 0;
    expHalted = 0;
    prevValid = 0;
    accPrev = 0;
    accPrev2 = 0;
  endtask

  task automatic writeWord(input logic [2:0] a, input logic [7:0] d);
    prog_we = 1'b1;
    prog_addr = a;
    prog_data = d;
    @(posedge clk); #1;
    memModel[a] = d;
    prog_we = 1'b0;
  endtask

  task automatic resetRelease();
    rst = 1'b0;
    @(posedge clk); #1;
    checkOutput("idle_valid", instr_valid, 0);
    monEnable = 1;
  endtask

  // Called so that the next rising edge is a FETCH edge; returns just after the
  // acceptance edge (or with execute still stalled when accept is 0).
  task automatic applyStimulus(input logic [2:0] addr, input int nStall, input bit accept,
                               input bit wrAtFetch, input logic [7:0] wdata);
    pc_in = addr;
    sb.push_back(memModel[addr]);
    if (wrAtFetch) begin
      prog_we = 1'b1;
      prog_addr = addr;
      prog_data = wdata;
    end
    stall = (nStall > 0) || !accept;
    @(posedge clk); #1;
    if (wrAtFetch) begin
      memModel[addr] = wdata;
      prog_we = 1'b0;
    end
    for (int i = 0; i < nStall; i++) begin
      pc_in = 3'($urandom_range(0, 7));
      if (randWrites && $urandom_range(0, 1) == 1) begin
        prog_we = 1'b1;
        prog_addr = 3'($urandom_range(1, 7));
        prog_data = 8'($urandom_range(0, 239));
      end
      @(posedge clk); #1;
      if (prog_we) memModel[prog_addr] = prog_data;
      prog_we = 1'b0;
    end
    if (accept) begin
      stall = 1'b0;
      @(posedge clk); #1;
    end
  endtask

  initial begin
    logic [7:0] program_init [8];
    logic [2:0] a;
    program_init = '{8'h10, 8'h21, 8'h32, 8'h43, 8'h54, 8'h65, 8'h76, 8'h87};
    rst = 1'b1;
    pc_in = 3'd0;
    prog_we = 1'b0;
    prog_addr = 3'd0;
    prog_data = 8'h00;
    stall = 1'b0;

    // Program is loaded while reset is held
    for (int i = 0; i < 8; i++) writeWord(3'(i), program_init[i]);
    doReset();
    resetRelease();

    for (int i = 0; i < 8; i++) applyStimulus(3'(i), 0, 1, 0, 8'h00);
    checkOutput("count_after_sequence", instr_count, 8);

    applyStimulus(3'd2, 3, 1, 0, 8'h00);

    // Same-cycle write and fetch of address 4, then refetch sees new word
    applyStimulus(3'd4, 0, 1, 1, 8'hAA);
    applyStimulus(3'd4, 0, 1, 0, 8'h00);

    doReset();
    resetRelease();
    for (int i = 0; i < 17; i++) applyStimulus(3'($urandom_range(0, 7)), 0, 1, 0, 8'h00);
    checkOutput("count_wrap", instr_count, 1);

    randWrites = 1;
    for (int i = 0; i < 40; i++) begin
      a = 3'($urandom_range(0, 7));
      applyStimulus(a, $urandom_range(0, 3), 1, (a != 3'd0) && ($urandom_range(0, 3) == 0),
                    8'($urandom_range(0, 239)));
    end
    randWrites = 0;

    applyStimulus(3'd5, 0, 0, 0, 8'h00);
    repeat (2) begin
      @(posedge clk); #1;
    end
    doReset();
    resetRelease();
    applyStimulus(3'd0, 0, 1, 0, 8'h00);

    doReset();
    writeWord(3'd3, 8'hF5);
    resetRelease();
    applyStimulus(3'd1, 0, 1, 0, 8'h00);
    applyStimulus(3'd3, 0, 1, 0, 8'h00);
    for (int i = 0; i < 10; i++) begin
      pc_in = 3'($urandom_range(0, 7));
      stall = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
    end

    doReset();
    resetRelease();
    applyStimulus(3'd0, 1, 1, 0, 8'h00);
    applyStimulus(3'd3, 0, 1, 0, 8'h00);
    repeat (3) begin
      @(posedge clk); #1;
    end

    checkOutput("scoreboard_drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
